dram_fifo_m: RTL and testbench
==============================

// Module: dram_fifo_m
// PURPOSE
//  Synchronous valid/ready FIFO whose storage is an sdp_distributed_ram_m instance (OUT_REGISTERED="NO").
//  Sits directly upstream of the RAM: owns write/read pointers, drives we/waddr/data_in/raddr, presents
//  the RAM's async read word as a first-word-fall-through head. Used to buffer short bursts between stages.
// PARAMETERS
//  ADDR_WIDTH   4    RAM address width; DEPTH = 2**ADDR_WIDTH words
//  WORD_WIDTH   32   data word width
//  AFULL_LEVEL  DEPTH-2  almost_full asserts when count >= AFULL_LEVEL (legal range 1..DEPTH)
// PORTS
//  clk          in   1             clock, all logic on posedge
//  rst_n        in   1             synchronous reset, active low
//  in_valid     in   1             producer word valid
//  in_ready     out  1             FIFO can accept (not full, not in reset)
//  in_data      in   WORD_WIDTH    producer word
//  out_valid    out  1             head word valid (count != 0)
//  out_ready    in   1             consumer accepts head
//  out_data     out  WORD_WIDTH    head word = ram[rptr], combinational from RAM read port
//  count        out  ADDR_WIDTH+1  current occupancy 0..DEPTH
//  almost_full  out  1             count >= AFULL_LEVEL
//  max_count    out  ADDR_WIDTH+1  high-water mark (only with DRAM_FIFO_WMARK_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wptr=0, rptr=0, count=0; RAM contents not cleared.
//    Outputs during/after reset: in_ready=0 while rst_n=0, else !full; out_valid=0; almost_full=0; max_count=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Transfer is on the clock edge.
//  - Op decode (cmd_t): IDLE, PUSH, POP, PUSH_POP. PUSH: we=1, waddr=wptr, wptr+1, count+1.
//    POP: rptr+1, count-1. PUSH_POP: both pointers advance, count unchanged. IDLE: hold.
//  - Latency: word pushed at edge N is visible on out_data/out_valid after edge N (one cycle); no bypass.
//  - Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally; full/empty derived from count only.
//  - Full (count==DEPTH): in_ready=0; in_valid ignored. A pop in the same cycle frees a slot for NEXT cycle only.
//  - Empty (count==0): out_valid=0; out_ready ignored; out_data is don't-care. Push when empty -> POP not possible same cycle.
//  - Simultaneous push & pop at 0<count<DEPTH: PUSH_POP, occupancy stable, order preserved.
//  - Reset mid-traffic: any in-flight push at the reset edge is discarded; stale RAM data never surfaces (count=0).
//  - count, almost_full registered from next-state; in_ready/out_valid combinational from registered count.
//  - Arithmetic: count updates saturate-free by construction (guarded by in_ready/out_valid); no X on outputs after reset.
// CONFIGURATION
//  DRAM_FIFO_WMARK_EN defined: max_count port exists; register updates to next count when next count > max_count;
//    cleared only by reset.
//  Not defined: max_count port and register absent; all other behaviour identical.
// STRUCTURE
//  dram_fifo_pkg: cmd_t enum {IDLE, PUSH, POP, PUSH_POP}; function cmd_decode(push, pop) -> cmd_t.
//  Sub-module: one sdp_distributed_ram_m instance (ADDR_WIDTH, WORD_WIDTH, OUT_REGISTERED="NO").
//  Pointer/count/watermark logic in dram_fifo_m itself; no further hierarchy.
// TESTING (ADDR_WIDTH=2 -> DEPTH=4, AFULL_LEVEL=3, WORD_WIDTH=8)
//  1. Reset, then push 0xA1,0xA2 with out_ready=0 -> count=2, out_valid=1, out_data=0xA1; pop -> out_data=0xA2.
//  2. Push 0x10..0x13 -> count=4, in_ready=0, almost_full=1 from count 3; extra push 0x14 dropped; drain gives 0x10..0x13.
//  3. At count=2, hold in_valid=out_ready=1 for 10 cycles with incrementing data -> count stays 2, pointers wrap, order intact.
//  4. Full FIFO, in_valid=1 and out_ready=1 same cycle -> only pop; count 4->3; in_ready=1 next cycle.
//  5. Push 3 words, assert rst_n=0 one cycle with in_valid=1 -> count=0, out_valid=0, in_ready=0 in reset, 1 after.
//  6. With DRAM_FIFO_WMARK_EN: fill to 3, drain to 0, fill to 2 -> max_count=3; after reset max_count=0.

Source files
------------

// File: rtl/dram_fifo_pkg.sv
// Shared types for the distributed-RAM FIFO: the per-cycle operation code
// and the decode from handshake events to that code.
package dram_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PUSH     = 2'b01,
    POP      = 2'b10,
    PUSH_POP = 2'b11
  } cmd_t;

  // Map the two qualified handshake events onto a single operation.
  function automatic cmd_t cmd_decode(input logic push, input logic pop);
    cmd_t c;
    unique case ({pop, push})
      2'b01:   c = PUSH;
      2'b10:   c = POP;
      2'b11:   c = PUSH_POP;
      default: c = IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sdp_distributed_ram_m.sv
// Simple dual-port distributed RAM: one synchronous write port, one read
// port that is asynchronous (OUT_REGISTERED="NO") or registered ("YES").
// Contents are never reset.
module sdp_distributed_ram_m #(
  parameter int    ADDR_WIDTH     = 4,
  parameter int    WORD_WIDTH     = 32,
  parameter string OUT_REGISTERED = "NO"
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WORD_WIDTH-1:0] data_out
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: store on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= data_in;
  end

  generate
    if (OUT_REGISTERED == "YES") begin : g_reg_out
      // Registered read: word appears one cycle after the address.
      always_ff @(posedge clk) begin
        data_out <= mem[raddr];
      end
    end else begin : g_async_out
      // Asynchronous read: word follows the address combinationally.
      always_comb begin
        data_out = mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/dram_fifo_m.sv
// First-word-fall-through valid/ready FIFO built on an asynchronous-read
// distributed RAM. Full/empty come from the occupancy count only; the
// pointers are free-running and wrap naturally.
// Optional feature: define DRAM_FIFO_WMARK_EN to add the max_count
// high-water-mark port and register.
module dram_fifo_m
  import dram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_WIDTH  = 32,
  parameter int AFULL_LEVEL = (2**ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
`ifdef DRAM_FIFO_WMARK_EN
  , output logic [ADDR_WIDTH:0] max_count
`endif
);

  localparam int                DEPTH_I   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH   = DEPTH_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LVL  = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  push, pop;
  cmd_t                  cmd;

  // Handshake qualification; in_ready is held low during reset so a word
  // presented on the reset edge is never written.
  always_comb begin
    in_ready  = rst_n && (count != DEPTH);
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    cmd       = cmd_decode(push, pop);
  end

  // Next occupancy from the decoded operation.
  always_comb begin
    count_nxt = count;
    unique case (cmd)
      PUSH:    count_nxt = count + CNT_ONE;
      POP:     count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Pointer, count and almost_full state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_LVL);
    end
  end

`ifdef DRAM_FIFO_WMARK_EN
  // High-water mark: tracks the largest occupancy since reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_count <= '0;
    end else if (count_nxt > max_count) begin
      max_count <= count_nxt;
    end
  end
`endif

  sdp_distributed_ram_m #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .WORD_WIDTH     (WORD_WIDTH),
    .OUT_REGISTERED ("NO")
  ) u_ram (
    .clk      (clk),
    .we       (push),
    .waddr    (wptr),
    .data_in  (in_data),
    .raddr    (rptr),
    .data_out (out_data)
  );

endmodule

// File: tb/tb_dram_fifo_m.sv
// Bench for dram_fifo_m at DEPTH=4, AFULL_LEVEL=3, 8-bit words. Directed
// scenarios followed by random traffic; a queue-based reference model is
// checked every cycle by an independent monitor.
module tb_dram_fifo_m;

  localparam int AW = 2;
  localparam int WW = 8;
  localparam int DEPTH = 4;
  localparam int AFL = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic [AW:0]   count;
  logic          almost_full;
`ifdef DRAM_FIFO_WMARK_EN
  logic [AW:0]   max_count;
`endif

  int tests = 0;
  int fails = 0;

  dram_fifo_m #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .AFULL_LEVEL(AFL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
`ifdef DRAM_FIFO_WMARK_EN
    , .max_count (max_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue of words, plus the high-water mark.
  logic [WW-1:0] exp_q[$];
  int            model_max = 0;
  bit            known = 0;

  // Monitor: between edges, compare DUT outputs against the model, then
  // advance the model by what the coming edge will do.
  always @(negedge clk) begin
    bit acc, take;
    if (known) begin
      chk("in_ready",    in_ready,    (rst_n && exp_q.size() < DEPTH) ? 1 : 0);
      chk("out_valid",   out_valid,   (exp_q.size() != 0) ? 1 : 0);
      chk("count",       count,       exp_q.size());
      chk("almost_full", almost_full, (exp_q.size() >= AFL) ? 1 : 0);
`ifdef DRAM_FIFO_WMARK_EN
      chk("max_count",   max_count,   model_max);
`endif
      if (exp_q.size() != 0 && out_ready)
        chk("out_data", out_data, exp_q[0]);
    end
    if (!rst_n) begin
      exp_q.delete();
      model_max = 0;
      known = 1;
    end else if (known) begin
      acc  = in_valid && (exp_q.size() < DEPTH);
      take = out_ready && (exp_q.size() != 0);
      if (take) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(in_data);
      if (exp_q.size() > model_max) model_max = exp_q.size();
    end
  end

  task automatic cyc(input logic v, input logic [WW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    // 1: two pushes with consumer stalled, then one pop
    cyc(1'b1, 8'hA1, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0);
    chk("t1_count", count, 2);
    chk("t1_head", out_data, 8'hA1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t1_next_head", out_data, 8'hA2);
    drain(2);

    // 2: overfill; the fifth word must be dropped
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    chk("t2_count_full", count, 4);
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_afull", almost_full, 1);
    drain(6);

    // 3: steady-state push+pop at count 2 across pointer wrap
    cyc(1'b1, 8'h50, 1'b0);
    cyc(1'b1, 8'h51, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h52 + i), 1'b1);
    chk("t3_count_stable", count, 2);
    drain(4);

    // 4: full with both handshakes asserted -> pop only
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
    cyc(1'b1, 8'h3F, 1'b1);
    chk("t4_count", count, 3);
    chk("t4_in_ready", in_ready, 1);
    drain(5);

    // 5: reset in the middle of traffic with a push pending
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("t5_in_ready_in_reset", in_ready, 0);
    cyc(1'b1, 8'h7F, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("t5_count", count, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready_after", in_ready, 1);
    cyc(1'b0, 8'h00, 1'b1);

    // 6: watermark sequence (checked by the monitor when enabled)
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
    drain(3);
    for (int i = 0; i < 2; i++) cyc(1'b1, 8'(8'h98 + i), 1'b0);
`ifdef DRAM_FIFO_WMARK_EN
    chk("t6_max_count", max_count, 3);
`endif
    drain(3);
    do_reset();
`ifdef DRAM_FIFO_WMARK_EN
    chk("t6_max_after_reset", max_count, 0);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cyc(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 50));
    end
    rst_n = 1'b1;
    drain(6);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
